// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, FSM states, ALU encoding and control bundle for the multicycle MIPS core.
package mips_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2a;
   // 5-bit alucontrol codes shared with the existing controller; ALU_NOP marks an unsupported funct
   localparam logic [4:0] ALU_AND = 5'd0;
   localparam logic [4:0] ALU_OR  = 5'd1;
   localparam logic [4:0] ALU_ADD = 5'd2;
   localparam logic [4:0] ALU_SUB = 5'd6;
   localparam logic [4:0] ALU_SLT = 5'd7;
   localparam logic [4:0] ALU_NOP = 5'd31;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
   } state_t;
   typedef enum logic [1:0] {PC_SEQ, PC_BR, PC_JMP} pcsrc_t;
   typedef struct packed {
      logic       memreq;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       ldab;
      logic       ldalu;
      logic       ldmdr;
      logic       regwrite;
      logic       wsel_rd;
      logic       memtoreg;
      logic       pcwrite;
      pcsrc_t     pcsrc;
      logic       alusrc_imm;
      logic [4:0] alucontrol;
   } ctrl_t;
   function automatic logic [4:0] funct_alu(input logic [5:0] f);
      return f == FN_ADD ? ALU_ADD : f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND :
             f == FN_OR ? ALU_OR : f == FN_SLT ? ALU_SLT : ALU_NOP;
   endfunction
endpackage

// File: rtl/mips_mem_if.sv
// mips_mem_if: unified instruction/data memory request bus of the multicycle core.
interface mips_mem_if;
   logic [31:0] memaddr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        memreq;
   logic        memwrite;
   logic        memready;
   modport master (output memaddr, memreq, memwrite, writedata, input readdata, memready);
   modport slave  (input memaddr, memreq, memwrite, writedata, output readdata, memready);
endinterface

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle FSM and instruction decode driving the datapath control bundle.
module mips_mc_controller
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       memready,
   input  logic       eq,
   output ctrl_t      ctrl,
   output logic       illegal
);
   state_t state, next;
   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= next;
   end
   always_comb begin
      next = state;
      case (state)
         FETCH:  next = memready ? DECODE : FETCH;
         DECODE: next = (op == OP_LW || op == OP_SW) ? MEMADR :
                        op == OP_ADDI ? ADDIEX : op == OP_BEQ ? BRANCH : op == OP_J ? JUMP :
                        (op == OP_RTYPE && funct_alu(funct) != ALU_NOP) ? EXEC : HALT;
         MEMADR: next = op == OP_LW ? MEMRD : MEMWR;
         MEMRD:  next = memready ? MEMWB : MEMRD;
         MEMWR:  next = memready ? FETCH : MEMWR;
         EXEC:   next = ALUWB;
         ADDIEX: next = ADDIWB;
         MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: next = FETCH;
         default: next = HALT;
      endcase
   end
   // every exit edge that retires an instruction carries pcwrite
   always_comb begin
      ctrl = '0;
      ctrl.alucontrol = ALU_ADD;
      case (state)
         FETCH:  begin ctrl.memreq = 1'b1; ctrl.irwrite = memready; end
         DECODE: ctrl.ldab = 1'b1;
         MEMADR: begin ctrl.alusrc_imm = 1'b1; ctrl.ldalu = 1'b1; end
         MEMRD:  begin ctrl.memreq = 1'b1; ctrl.iord = 1'b1; ctrl.ldmdr = memready; end
         MEMWB:  begin ctrl.regwrite = 1'b1; ctrl.memtoreg = 1'b1; ctrl.pcwrite = 1'b1; end
         MEMWR:  begin
            ctrl.memreq = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.iord = 1'b1;
            ctrl.pcwrite = memready;
         end
         EXEC:   begin ctrl.alucontrol = funct_alu(funct); ctrl.ldalu = 1'b1; end
         ALUWB:  begin ctrl.regwrite = 1'b1; ctrl.wsel_rd = 1'b1; ctrl.pcwrite = 1'b1; end
         ADDIEX: begin ctrl.alusrc_imm = 1'b1; ctrl.ldalu = 1'b1; end
         ADDIWB: begin ctrl.regwrite = 1'b1; ctrl.pcwrite = 1'b1; end
         BRANCH: begin ctrl.pcwrite = 1'b1; ctrl.pcsrc = eq ? PC_BR : PC_SEQ; end
         JUMP:   begin ctrl.pcwrite = 1'b1; ctrl.pcsrc = PC_JMP; end
         default: ;
      endcase
   end
   assign illegal = state == HALT;
endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS subset core; datapath registers, ALU and register file around the controller.
module mips_multicycle
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   output logic        illegal,
   mips_mem_if.master  mem
);
   localparam int AW = $clog2(NREGS);
   logic [31:0] instr, a, b, aluout, mdr, alu_y, srcb, simm, pc4, target, wdata;
   logic [31:0] rf [NREGS];
   logic [AW-1:0] ra, rb, wa;
   ctrl_t ctrl;
   mips_mc_controller u_ctrl (
      .clk(clk),
      .reset(reset),
      .op(instr[31:26]),
      .funct(instr[5:0]),
      .memready(mem.memready),
      .eq(a == b),
      .ctrl(ctrl),
      .illegal(illegal)
   );
   assign simm   = {{16{instr[15]}}, instr[15:0]};
   assign pc4    = pc + 32'd4;
   assign target = pc4 + {simm[29:0], 2'b00};
   assign ra     = instr[21 +: AW];
   assign rb     = instr[16 +: AW];
   assign wa     = ctrl.wsel_rd ? instr[11 +: AW] : rb;
   assign srcb   = ctrl.alusrc_imm ? simm : b;
   assign wdata  = ctrl.memtoreg ? mdr : aluout;
   assign mem.memaddr   = ctrl.iord ? aluout : pc;
   assign mem.memreq    = ctrl.memreq;
   assign mem.memwrite  = ctrl.memwrite;
   assign mem.writedata = b;
   always_comb begin
      alu_y = ctrl.alucontrol == ALU_ADD ? a + srcb :
              ctrl.alucontrol == ALU_SUB ? a - srcb :
              ctrl.alucontrol == ALU_AND ? a & srcb :
              ctrl.alucontrol == ALU_OR  ? a | srcb :
              ctrl.alucontrol == ALU_SLT ? {31'b0, $signed(a) < $signed(srcb)} : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pc    <= RESET_PC;
         instr <= '0;
      end else begin
         if (ctrl.irwrite) instr <= mem.readdata;
         if (ctrl.pcwrite)
            pc <= ctrl.pcsrc == PC_BR ? target :
                  ctrl.pcsrc == PC_JMP ? {pc4[31:28], instr[25:0], 2'b00} : pc4;
      end
   end
   // register file is never reset; reset only blocks in-flight updates
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (ctrl.ldab) begin
            a <= ra == '0 ? '0 : rf[ra];
            b <= rb == '0 ? '0 : rf[rb];
         end
         if (ctrl.ldalu) aluout <= alu_y;
         if (ctrl.ldmdr) mdr <= mem.readdata;
         if (ctrl.regwrite && wa != '0) rf[wa] <= wdata;
      end
   end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed program vectors and hand-written handshake/reset sequences for mips_multicycle.
module tb_mips_multicycle;
   localparam logic [31:0] ILL = 32'hFC00_0000;
   typedef logic [5:0][31:0] prog_t;
   typedef struct packed { prog_t prog; logic [31:0] ea; logic [31:0] ed; } vec_t;
   typedef struct packed { logic [31:0] ins; logic [31:0] cyc; } cyc_t;
   logic clk = 1'b0, reset = 1'b1, rdy = 1'b1;
   logic [31:0] pc;
   logic illegal;
   logic [31:0] mem [256];
   logic [31:0] wr_addr, wr_data;
   int checks = 0, failures = 0, wr_cnt = 0;
   vec_t vec [14];
   cyc_t cv [6];
   mips_mem_if bus ();
   mips_multicycle #(.RESET_PC(32'h100), .NREGS(32)) dut (
      .clk(clk), .reset(reset), .pc(pc), .illegal(illegal), .mem(bus)
   );
   always #5 clk = ~clk;
   assign bus.memready = rdy;
   assign bus.readdata = rdy ? mem[bus.memaddr[9:2]] : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (!reset && bus.memreq && bus.memwrite && bus.memready) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus.memaddr;
         wr_data <= bus.writedata;
      end
   end
   function automatic logic [31:0] f_addi(input logic [4:0] rt, rs, input logic [15:0] imm);
      return {6'h08, rs, rt, imm};
   endfunction
   function automatic logic [31:0] f_lw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] rs);
      return {6'h23, rs, rt, off};
   endfunction
   function automatic logic [31:0] f_sw(input logic [4:0] rt, input logic [15:0] off, input logic [4:0] rs);
      return {6'h2b, rs, rt, off};
   endfunction
   function automatic logic [31:0] f_beq(input logic [4:0] rs, rt, input logic [15:0] off);
      return {6'h04, rs, rt, off};
   endfunction
   function automatic logic [31:0] f_r(input logic [4:0] rd, rs, rt, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction
   function automatic logic [31:0] f_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction
   function automatic prog_t pg(input logic [31:0] w0, w1 = ILL, w2 = ILL, w3 = ILL, w4 = ILL, w5 = ILL);
      prog_t p;
      p[0] = w0; p[1] = w1; p[2] = w2; p[3] = w3; p[4] = w4; p[5] = w5;
      return p;
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic load(input prog_t p);
      for (int k = 0; k < 256; k++) mem[k] = ILL;
      mem[16] = 32'hDEAD_BEEF;
      for (int k = 0; k < 6; k++) mem[64 + k] = p[k];
   endtask
   task automatic do_reset();
      rdy = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_wr(input string nm, input logic [31:0] ea, input logic [31:0] ed);
      int c0;
      int n;
      c0 = wr_cnt;
      n = 0;
      while (wr_cnt == c0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_done"}, {31'b0, wr_cnt != c0}, 32'd1);
      chk({nm, "_addr"}, wr_addr, ea);
      chk({nm, "_data"}, wr_data, ed);
   endtask
   initial begin
      int n;
      logic ok;
      vec[0]  = '{pg(f_addi(2, 0, 5), f_addi(3, 0, 7), f_r(4, 2, 3, 6'h20), f_sw(4, 8, 0)), 32'h8, 32'd12};
      vec[1]  = '{pg(f_addi(2, 0, 3), f_addi(3, 0, 5), f_r(4, 2, 3, 6'h22), f_sw(4, 12, 0)), 32'hC, 32'hFFFF_FFFE};
      vec[2]  = '{pg(f_addi(2, 0, 16'h0F0F), f_addi(3, 0, 16'h00FF), f_r(4, 2, 3, 6'h24), f_sw(4, 16, 0)), 32'h10, 32'h000F};
      vec[3]  = '{pg(f_addi(2, 0, 16'h0F0F), f_addi(3, 0, 16'h00FF), f_r(4, 2, 3, 6'h25), f_sw(4, 20, 0)), 32'h14, 32'h0FFF};
      vec[4]  = '{pg(f_addi(2, 0, 16'hFFFF), f_addi(3, 0, 1), f_r(4, 2, 3, 6'h2a), f_sw(4, 24, 0)), 32'h18, 32'd1};
      vec[5]  = '{pg(f_addi(2, 0, 16'hFFFF), f_addi(3, 0, 1), f_r(4, 3, 2, 6'h2a), f_sw(4, 28, 0)), 32'h1C, 32'd0};
      vec[6]  = '{pg(f_addi(0, 0, 7), f_sw(0, 32, 0)), 32'h20, 32'd0};
      vec[7]  = '{pg(f_lw(5, 16'h40, 0), f_sw(5, 36, 0)), 32'h24, 32'hDEAD_BEEF};
      vec[8]  = '{pg(f_addi(2, 0, 1), f_beq(0, 0, 1), f_addi(2, 0, 2), f_sw(2, 40, 0)), 32'h28, 32'd1};
      vec[9]  = '{pg(f_addi(2, 0, 1), f_beq(2, 0, 1), f_addi(2, 0, 2), f_sw(2, 44, 0)), 32'h2C, 32'd2};
      vec[10] = '{pg(f_addi(2, 0, 3), f_j(26'h44), f_addi(2, 0, 9), ILL, f_sw(2, 48, 0)), 32'h30, 32'd3};
      vec[11] = '{pg(f_addi(2, 0, 16'hFFFF), f_r(3, 2, 2, 6'h20), f_sw(3, 52, 0)), 32'h34, 32'hFFFF_FFFE};
      vec[12] = '{pg(f_addi(6, 0, 16'h40), f_lw(7, 0, 6), f_sw(7, 56, 0)), 32'h38, 32'hDEAD_BEEF};
      vec[13] = '{pg(f_addi(6, 0, 16'h50), f_sw(6, 16'hFFFC, 6)), 32'h4C, 32'h50};
      cv[0] = '{f_addi(2, 0, 5), 32'd4};
      cv[1] = '{f_r(4, 2, 3, 6'h20), 32'd4};
      cv[2] = '{f_lw(5, 16'h40, 0), 32'd5};
      cv[3] = '{f_sw(0, 8, 0), 32'd4};
      cv[4] = '{f_beq(0, 0, 0), 32'd3};
      cv[5] = '{f_j(26'h80), 32'd3};
      // reset state at RESET_PC
      load(pg(f_addi(2, 0, 5)));
      do_reset();
      chk("rst_addr", bus.memaddr, 32'h100);
      chk("rst_req_we", {30'b0, bus.memreq, bus.memwrite}, 32'd2);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_pc", pc, 32'h100);
      for (int i = 0; i < 14; i++) begin
         load(vec[i].prog);
         do_reset();
         wait_wr($sformatf("vec%0d", i), vec[i].ea, vec[i].ed);
      end
      // zero-wait latency: edges until pc leaves RESET_PC
      for (int i = 0; i < 6; i++) begin
         load(pg(cv[i].ins));
         do_reset();
         n = 0;
         while (pc == 32'h100 && n < 20) begin
            step(1);
            n++;
         end
         chk($sformatf("cyc%0d", i), n, cv[i].cyc);
      end
      // beq loop at 0x20
      load(pg(f_j(26'h8)));
      mem[8] = f_beq(0, 0, 16'hFFFF);
      do_reset();
      step(3);
      chk("beq_at20", pc, 32'h20);
      step(1);
      chk("beq_hold", pc, 32'h20);
      step(2);
      chk("beq_loop_pc", pc, 32'h20);
      chk("beq_loop_addr", bus.memaddr, 32'h20);
      load(pg(f_addi(2, 0, 1), f_j(26'h8)));
      mem[8] = f_beq(2, 0, 16'hFFFF);
      do_reset();
      step(10);
      chk("beq_ne_pc", pc, 32'h24);
      // lw with three wait cycles in MEMRD
      load(pg(f_lw(5, 16'h40, 0), f_sw(5, 60, 0)));
      do_reset();
      step(3);
      for (int k = 0; k < 4; k++) begin
         rdy = k == 3;
         #1;
         chk($sformatf("lw_wait%0d_addr", k), bus.memaddr, 32'h40);
         chk($sformatf("lw_wait%0d_req", k), {30'b0, bus.memreq, bus.memwrite}, 32'd2);
         chk($sformatf("lw_wait%0d_pc", k), pc, 32'h100);
         step(1);
      end
      chk("lw_wb_pc", pc, 32'h100);
      wait_wr("lw_wait_sw", 32'h3C, 32'hDEAD_BEEF);
      // illegal opcode halts until reset
      load(pg(ILL));
      do_reset();
      step(2);
      chk("ill_flag", {31'b0, illegal}, 32'd1);
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         rdy = k[0];
         ok &= illegal && !bus.memreq && pc == 32'h100;
         step(1);
      end
      chk("ill_hold20", {31'b0, ok}, 32'd1);
      reset = 1'b1;
      rdy = 1'b1;
      step(1);
      chk("ill_reset_flag", {31'b0, illegal}, 32'd0);
      chk("ill_reset_req", {31'b0, bus.memreq}, 32'd1);
      load(pg(f_r(4, 2, 3, 6'h21)));
      do_reset();
      step(2);
      chk("ill_funct", {31'b0, illegal}, 32'd1);
      // reset during a stalled store
      load(pg(f_addi(2, 0, 5), f_sw(2, 8, 0)));
      do_reset();
      step(7);
      rdy = 1'b0;
      #1;
      chk("sw_wait_req", {30'b0, bus.memreq, bus.memwrite}, 32'd3);
      chk("sw_wait_addr", bus.memaddr, 32'h8);
      step(2);
      chk("sw_stable_addr", bus.memaddr, 32'h8);
      chk("sw_stable_data", bus.writedata, 32'd5);
      n = wr_cnt;
      reset = 1'b1;
      rdy = 1'b1;
      step(1);
      reset = 1'b0;
      chk("sw_rst_nowrite", wr_cnt, n);
      chk("sw_rst_pc", pc, 32'h100);
      chk("sw_rst_addr", bus.memaddr, 32'h100);
      chk("sw_rst_req", {30'b0, bus.memreq, bus.memwrite}, 32'd2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mips_multicycle.md
MIPS_MULTICYCLE -- requirements
Module: mips_multicycle

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 Parameter NREGS, default 32, meaning register-file depth; legal values 16 or 32; register index is instr bits [4+log2(NREGS)-1 ..] truncated to log2(NREGS) bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  output  32  architectural PC of the instruction in progress.
REQ-006 memaddr  output  32  unified instruction/data memory byte address.
REQ-007 memreq  output  1  memory request valid.
REQ-008 memwrite  output  1  request is a write; qualified by memreq.
REQ-009 writedata  output  32  store data; qualified by memreq and memwrite.
REQ-010 readdata  input  32  load/fetch data; sampled when memreq and memready are both high.
REQ-011 memready  input  1  memory accepts/completes the current request this cycle.
REQ-012 illegal  output  1  sticky flag: unsupported opcode/funct decoded; core halted.

Function
REQ-013 Supported: R-type add, sub, and, or, slt; lw, sw, beq, addi, j; all else illegal.
REQ-014 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT.
REQ-015 FETCH: memreq=1, memwrite=0, memaddr=pc; hold until memready; on memready latch instr, go DECODE.
REQ-016 DECODE: read rs/rt into A/B, compute pc+4 and branch target pc+4+(signext(imm)<<2); dispatch on opcode.
REQ-017 lw: MEMADR (A+signext imm) -> MEMRD (memreq=1, memwrite=0, wait memready) -> MEMWB (rt<=data) -> FETCH.
REQ-018 sw: MEMADR -> MEMWR (memreq=1, memwrite=1, writedata=B, wait memready) -> FETCH.
REQ-019 R-type: EXEC -> ALUWB (rd<=result) -> FETCH; addi: ADDIEX -> ADDIWB (rt<=A+signext imm) -> FETCH.
REQ-020 beq: BRANCH; pc<=target if A==B else pc+4; -> FETCH.
REQ-021 j: JUMP; pc<={pc+4[31:28], instr[25:0], 2'b00}; -> FETCH.
REQ-022 Non-branch/jump instructions update pc<=pc+4 on their final state's exit edge, never earlier.
REQ-023 memaddr, memwrite, writedata SHALL stay stable while memreq=1 and memready=0; memreq SHALL not drop until memready.
REQ-024 memreq SHALL be 0 in every state except FETCH, MEMRD, MEMWR.
REQ-025 Zero-wait memory (memready tied 1): lw 5 cycles, sw 4, R-type/addi 4, beq/j 3; each wait cycle adds one.
REQ-026 Register 0 reads zero; writes to it are discarded.
REQ-027 ALU is 32-bit two's complement; add/sub wrap silently, no overflow trap; slt signed.
REQ-028 Illegal decode: go HALT, set illegal=1, pc frozen, memreq=0; exit only by reset.
REQ-029 Write to a register read by the next instruction SHALL be visible (writeback precedes next DECODE).

Reset
REQ-030 reset SHALL dominate all other inputs on the same edge, including a pending memready.
REQ-031 After reset: state=FETCH, pc=RESET_PC, memreq=1 in the first post-reset cycle, memwrite=0, illegal=0, instr register=0.
REQ-032 Reset mid-transaction SHALL abandon the request without completing a register or PC update.
REQ-033 Register-file contents are not reset.

Structure
REQ-034 Package mips_pkg SHALL hold opcode/funct constants, the FSM state enum, and the 5-bit alucontrol encoding shared with the existing controller.
REQ-035 One sub-module mips_mc_controller SHALL contain the FSM and decode; datapath registers, ALU and register file stay in mips_multicycle.

Verification
REQ-036 Reset with RESET_PC=32'h100, memready=1 -> first cycle memreq=1, memaddr=32'h100, memwrite=0.
REQ-037 Program addi $2,$0,5; addi $3,$0,7; add $4,$2,$3; sw $4,8($0) -> write at memaddr 32'h8, writedata 12.
REQ-038 lw with memready low 3 cycles in MEMRD -> memaddr/memreq stable 4 cycles, rt loaded only after memready.
REQ-039 beq $0,$0,-1 at pc 32'h20 -> pc returns to 32'h20; beq with unequal operands -> pc 32'h24.
REQ-040 Opcode 6'h3F fetched -> illegal=1, memreq=0 thereafter, pc unchanged for 20 cycles; reset clears.
REQ-041 reset asserted during MEMWR wait -> no write completes, next cycle FETCH at RESET_PC.
